// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder arbiter: FSM encoding and ID width.
// Encoding 2'd3 is unused and steers the FSM back to IDLE.
package serial_add_pkg;

    localparam int ID_W = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Bit-serial full-adder slice: two cascaded half adders plus a carry flop.
// The carry flop has an async reset and a synchronous clear for the start of a new add.
module serial_fa_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic a,
    input  logic b,
    output logic s,
    output logic c_q
);

    logic w_p;
    logic w_g1;
    logic w_g2;

    serial_half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (w_p),
        .c (w_g1)
    );

    serial_half_adder u_ha1 (
        .a (w_p),
        .b (c_q),
        .s (s),
        .c (w_g2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= 1'b0;
        end else if (clr) begin
            c_q <= 1'b0;
        end else begin
            c_q <= w_g1 | w_g2;
        end
    end

endmodule

// File: rtl/serial_half_adder.sv
// Single half-adder cell (XOR sum, AND carry) used to build the serial full adder.
module serial_half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin arbiter sharing one bit-serial full adder.
// Operands are added LSB-first, one bit per clock; results leave over a valid/ready port.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);

    import serial_add_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_rrPtr;
    logic [ID_W-1:0]   r_id;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_grant;
    logic              w_idle;
    logic              w_accept;
    logic              w_handshake;
    logic              w_shifting;
    logic              w_cellA;
    logic              w_cellB;
    logic              w_s;
    logic              w_carry;

    // Ready is gated by reset so every output reads 0 while rst is held.
    always_comb begin
        w_grant    = (req0_valid && req1_valid) ? r_rrPtr : req1_valid;
        w_idle     = (r_state == IDLE) && !rst;
        req0_ready = w_idle && req0_valid && !w_grant;
        req1_ready = w_idle && req1_valid && w_grant;
        w_accept   = req0_ready || req1_ready;
        w_shifting = (r_state == SHIFT);
        res_valid  = (r_state == DONE);
        w_handshake = res_valid && res_ready;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(WIDTH - 1)) w_nextState = DONE;
            DONE:    if (res_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Outside SHIFT both cell inputs follow the carry, so maj(c,c,c) holds it.
    assign w_cellA = w_shifting ? r_a[0] : w_carry;
    assign w_cellB = w_shifting ? r_b[0] : w_carry;

    serial_fa_cell u_fa (
        .clk (clk),
        .rst (rst),
        .clr (w_accept),
        .a   (w_cellA),
        .b   (w_cellB),
        .s   (w_s),
        .c_q (w_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_cnt <= '0;
            r_id  <= '0;
        end else if (w_accept) begin
            r_a   <= w_grant ? req1_a : req0_a;
            r_b   <= w_grant ? req1_b : req0_b;
            r_id  <= w_grant;
            r_cnt <= '0;
        end else if (w_shifting) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_sum <= {w_s, r_sum[WIDTH-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The requester just served loses priority for the next contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rrPtr <= 1'b0;
        end else if (w_handshake) begin
            r_rrPtr <= ~r_id[0];
        end
    end

    assign res_sum  = r_sum;
    assign res_cout = w_carry;
    assign res_id   = r_id[0];

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result handshake occurs.
module tb_serial_add_arbiter;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             id;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic             req1_ready;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    exp_t sbQ[$];
    exp_t popped;
    int   total = 0;
    int   bad = 0;

    serial_add_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    // Monitor: ready exclusivity and result scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_ready || req1_ready) begin
                total++;
                if (req0_ready && req1_ready) begin
                    bad++;
                    $display("[TB] FAIL double_ready: got req0_ready=%0b req1_ready=%0b required at most one", req0_ready, req1_ready);
                end
            end
            if (res_valid && res_ready) begin
                total++;
                if (sbQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL spurious_result: got sum=%h cout=%0b id=%0b required no result", res_sum, res_cout, res_id);
                end else begin
                    popped = sbQ.pop_front();
                    if (res_sum !== popped.sum || res_cout !== popped.cout || res_id !== popped.id) begin
                        bad++;
                        $display("[TB] FAIL result: got sum=%h cout=%0b id=%0b required sum=%h cout=%0b id=%0b", res_sum, res_cout, res_id, popped.sum, popped.cout, popped.id);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    // Present one request, wait for its ready, record the expected result, then release.
    task automatic applyStimulus(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] expSum, input logic expCout);
        int waitCnt;
        bit got;
        waitCnt = 0;
        got = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        while (!got && waitCnt < 100) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                sbQ.push_back('{sum: expSum, cout: expCout, id: id});
            end else begin
                waitCnt++;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("[TB] FAIL accept_timeout: got no ready for req%0d required ready within 100 cycles", id);
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sbQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s: got %0d pending results required 0", name, sbQ.size());
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        sbQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] orderA [4];
        logic [WIDTH-1:0] orderB [4];
        logic [WIDTH-1:0] orderS [4];
        logic             orderC [4];
        logic             orderId [4];
        int n;
        bit got;
        logic gotId;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_sum", res_sum, 0);
        rst = 1'b0;
        #1;
        checkOutput("init_res_valid", res_valid, 0);
        checkOutput("init_res_sum", res_sum, 0);
        checkOutput("init_res_cout", res_cout, 0);
        checkOutput("init_res_id", res_id, 0);
        checkOutput("init_req0_ready", req0_ready, 0);
        checkOutput("init_req1_ready", req1_ready, 0);

        // 1: basic add with latency check
        applyStimulus(1'b0, 8'h0F, 8'h01, 8'h10, 1'b0);
        repeat (WIDTH - 1) @(posedge clk);
        #1;
        checkOutput("t1_valid_early", res_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("t1_valid_on_time", res_valid, 1);
        waitDrain("t1_drain");

        // 2: overflow cases
        applyStimulus(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1);
        waitDrain("t2a_drain");
        applyStimulus(1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1);
        waitDrain("t2b_drain");

        // 3: both held valid after reset, grant alternates starting with req0
        doReset();
        orderId = '{1'b0, 1'b1, 1'b0, 1'b1};
        req0_a = 8'h55; req0_b = 8'hAA;
        req1_a = 8'h80; req1_b = 8'h80;
        for (int k = 0; k < 4; k++) begin
            orderA[k] = orderId[k] ? 8'h80 : 8'h55;
            orderB[k] = orderId[k] ? 8'h80 : 8'hAA;
            orderS[k] = orderId[k] ? 8'h00 : 8'hFF;
            orderC[k] = orderId[k] ? 1'b1 : 1'b0;
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            n = 0;
            gotId = 1'b0;
            while (!got && n < 100) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got = 1'b1;
                    gotId = req1_ready;
                    sbQ.push_back('{sum: orderS[k], cout: orderC[k], id: orderId[k]});
                end else begin
                    n++;
                end
            end
            checkOutput("t3_grant_seen", got, 1);
            checkOutput("t3_grant_id", gotId, orderId[k]);
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitDrain("t3_drain");

        // 4: consumer stalls in DONE; outputs hold and no request is accepted
        res_ready = 1'b0;
        applyStimulus(1'b0, 8'h12, 8'h34, 8'h46, 1'b0);
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t4_valid_seen", res_valid, 1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t4_hold_valid", res_valid, 1);
            checkOutput("t4_hold_sum", res_sum, 8'h46);
            checkOutput("t4_hold_cout", res_cout, 0);
            checkOutput("t4_hold_id", res_id, 0);
            checkOutput("t4_req0_ready", req0_ready, 0);
            checkOutput("t4_req1_ready", req1_ready, 0);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        waitDrain("t4_drain");

        // 5: reset mid-add at cnt=3, then req0 must win a contested grant
        applyStimulus(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sbQ.delete();
        checkOutput("t5_res_valid", res_valid, 0);
        checkOutput("t5_res_sum", res_sum, 0);
        checkOutput("t5_res_cout", res_cout, 0);
        checkOutput("t5_res_id", res_id, 0);
        checkOutput("t5_req0_ready", req0_ready, 0);
        checkOutput("t5_req1_ready", req1_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'hC8; req0_b = 8'h64;
        req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02;
        @(negedge clk);
        checkOutput("t5_post_req0_ready", req0_ready, 1);
        checkOutput("t5_post_req1_ready", req1_ready, 0);
        if (req0_ready) sbQ.push_back('{sum: 8'h2C, cout: 1'b1, id: 1'b0});
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitDrain("t5_drain");

        // 6: short req0 pulse during SHIFT is never accepted
        applyStimulus(1'b1, 8'h3C, 8'h0F, 8'h4B, 1'b0);
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
        @(negedge clk);
        checkOutput("t6_pulse_ready", req0_ready, 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        waitDrain("t6_drain");
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t6_no_spurious_valid", res_valid, 0);
        checkOutput("final_queue_empty", sbQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
